data_memory_banked: RTL and testbench

//  Parametrised successor of the single-cycle word data memory. Byte-addressed, with byte, half and word accesses

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_lane_align.sv | 62 ++++++
 rtl/data_memory_banked.sv | 193 +++++++++++++++++++
 tb/tb_data_memory_banked.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the banked data memory.
// Contents: access-size codes, FSM state encoding, byte parity helper.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Even-parity bit for one byte: byte plus this bit holds an even number of ones.
    function automatic logic even_parity(input logic [7:0] byte_val);
        return ^byte_val;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for byte/half/word accesses.
// Ports:
//   addr_lo     in   2   byte offset within the word (Address[1:0])
//   size        in   2   access size code (SIZE_BYTE/HALF/WORD, 3 illegal)
//   zero_ext    in   1   1: zero-extend loads, 0: sign-extend
//   store_data  in  32   LSB-aligned store data
//   read_word   in  32   full word read from the array
//   lane_mask   out  4   byte lanes touched by the access
//   store_lanes out 32   store data replicated onto every candidate lane
//   load_data   out 32   selected lane(s) shifted to the LSBs and extended
//   misaligned  out  1   alignment violation or illegal size
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    output logic [3:0]  lane_mask,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted_s;

    // Decode lanes, replicate store data and extract/extend load data.
    always_comb begin
        lane_mask   = 4'b0000;
        store_lanes = 32'd0;
        load_data   = 32'd0;
        misaligned  = 1'b0;
        // Move the addressed byte to bit 0; for halves addr_lo is 0 or 2 when aligned.
        shifted_s   = read_word >> {addr_lo, 3'b000};
        case (size)
            SIZE_BYTE: begin
                lane_mask   = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
                load_data   = zero_ext ? {24'd0, shifted_s[7:0]}
                                       : {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
            SIZE_HALF: begin
                lane_mask   = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{store_data[15:0]}};
                load_data   = zero_ext ? {16'd0, shifted_s[15:0]}
                                       : {{16{shifted_s[15]}}, shifted_s[15:0]};
                misaligned  = addr_lo[0];
            end
            SIZE_WORD: begin
                lane_mask   = 4'b1111;
                store_lanes = store_data;
                load_data   = read_word;
                misaligned  = (addr_lo != 2'b00);
            end
            default: begin
                misaligned  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_banked.sv
// Byte-addressed data memory with byte/half/word lanes, valid/ready request,
// configurable read wait states and a one-cycle response pulse.
// Optional feature macro: DMEM_PARITY_EN (per-byte even parity, ParityError port).
// Ports:
//   Clock, Reset (sync, active-high)
//   ReqValid/ReqReady    request handshake; ReqReady high only in IDLE
//   MemoryRead/Write     load/store selects (both high is an error)
//   Address, Size, Unsigned, WriteData   request fields, sampled at accept
//   RespValid            one-cycle pulse qualifying ReadData/AccessError(/ParityError)
module data_memory_banked
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  MemoryRead,
    input  logic                  MemoryWrite,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    input  logic [31:0]           WriteData,
    output logic                  RespValid,
    output logic [31:0]           ReadData,
    output logic                  AccessError
`ifdef DMEM_PARITY_EN
    ,
    output logic                  ParityError
`endif
);

    localparam int         IW        = ADDR_WIDTH - 2;
    localparam int         IDXW      = $clog2(DEPTH);
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES - 1);

    logic [31:0]     mem_r [DEPTH];
    dmem_state_e     state_r, state_next_s;
    logic [2:0]      wait_cnt_r;
    logic [31:0]     pend_data_r;
    logic            pend_err_r;

    logic [IW-1:0]   word_idx_s;
    logic [IDXW-1:0] mem_idx_s;
    logic            in_range_s;
    logic [31:0]     rd_word_s;
    logic [3:0]      lane_mask_s;
    logic [31:0]     store_lanes_s;
    logic [31:0]     load_data_s;
    logic            misaligned_s;
    logic            accept_s;
    logic            req_err_s;
    logic            store_s;
    logic [31:0]     fresh_data_s;

    assign word_idx_s = Address[ADDR_WIDTH-1:2];
    assign mem_idx_s  = word_idx_s[IDXW-1:0];
    assign in_range_s = 32'(word_idx_s) < 32'(DEPTH);
    assign rd_word_s  = in_range_s ? mem_r[mem_idx_s] : 32'd0;

    // Reset has priority so a request presented alongside it is never accepted.
    assign accept_s     = ReqValid & ReqReady & (MemoryRead | MemoryWrite) & ~Reset;
    assign req_err_s    = misaligned_s | ~in_range_s | (MemoryRead & MemoryWrite);
    assign store_s      = accept_s & MemoryWrite & ~req_err_s;
    assign fresh_data_s = (req_err_s | MemoryWrite) ? 32'd0 : load_data_s;

    dmem_lane_align u_align (
        .addr_lo     (Address[1:0]),
        .size        (Size),
        .zero_ext    (Unsigned),
        .store_data  (WriteData),
        .read_word   (rd_word_s),
        .lane_mask   (lane_mask_s),
        .store_lanes (store_lanes_s),
        .load_data   (load_data_s),
        .misaligned  (misaligned_s)
    );

    // Array byte-lane writes; no reset so contents survive Reset.
    always_ff @(posedge Clock) begin
        for (int i = 0; i < 4; i++) begin
            if (store_s && lane_mask_s[i]) begin
                mem_r[mem_idx_s][8*i +: 8] <= store_lanes_s[8*i +: 8];
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [3:0] par_r [DEPTH];
    logic       pend_par_r;
    logic       fresh_par_s;

    // Parity bit per byte, written together with its byte.
    always_ff @(posedge Clock) begin
        for (int i = 0; i < 4; i++) begin
            if (store_s && lane_mask_s[i]) begin
                par_r[mem_idx_s][i] <= even_parity(store_lanes_s[8*i +: 8]);
            end
        end
    end

    // Flag a mismatch in any lane the load selects.
    always_comb begin
        fresh_par_s = 1'b0;
        if (MemoryRead && !MemoryWrite && !req_err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask_s[i] &&
                    (par_r[mem_idx_s][i] != even_parity(rd_word_s[8*i +: 8]))) begin
                    fresh_par_s = 1'b1;
                end else begin
                    fresh_par_s = fresh_par_s;
                end
            end
        end else begin
            fresh_par_s = 1'b0;
        end
    end

    // Parity result follows the same pending/present path as the data.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pend_par_r  <= 1'b0;
            ParityError <= 1'b0;
        end else begin
            if (accept_s) begin
                pend_par_r <= fresh_par_s;
            end
            if (state_next_s == RESP && state_r != RESP) begin
                ParityError <= (state_r == IDLE) ? fresh_par_s : pend_par_r;
            end
        end
    end
`endif

    // Next-state logic: IDLE -> WAIT (skipped when no wait states) -> RESP -> IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = (WAIT_STATES == 0) ? RESP : WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, wait counter, pending result and registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 3'd0;
            pend_data_r <= 32'd0;
            pend_err_r  <= 1'b0;
            ReqReady    <= 1'b1;
            RespValid   <= 1'b0;
            ReadData    <= 32'd0;
            AccessError <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            ReqReady  <= (state_next_s == IDLE);
            RespValid <= (state_next_s == RESP);
            if (accept_s) begin
                wait_cnt_r  <= 3'd0;
                pend_data_r <= fresh_data_s;
                pend_err_r  <= req_err_s;
            end else if (state_r == WAIT) begin
                wait_cnt_r  <= wait_cnt_r + 3'd1;
            end else begin
                wait_cnt_r  <= wait_cnt_r;
            end
            // With zero wait states RESP follows accept directly, so take the fresh result.
            if (state_next_s == RESP && state_r != RESP) begin
                ReadData    <= (state_r == IDLE) ? fresh_data_s : pend_data_r;
                AccessError <= (state_r == IDLE) ? req_err_s    : pend_err_r;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_banked.sv
// Scoreboard bench for data_memory_banked: a byte-array reference model
// produces expected responses at issue time; a negedge monitor pops them
// whenever RespValid is seen.
module tb_data_memory_banked;

    localparam int DEPTH = 32;
    localparam int AW    = 8;
    localparam int WS    = 1;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          ReqValid;
    logic          ReqReady;
    logic          MemoryRead;
    logic          MemoryWrite;
    logic [AW-1:0] Address;
    logic [1:0]    Size;
    logic          Unsigned;
    logic [31:0]   WriteData;
    logic          RespValid;
    logic [31:0]   ReadData;
    logic          AccessError;
`ifdef DMEM_PARITY_EN
    logic          ParityError;
`endif

    always #5 Clock = ~Clock;

    data_memory_banked #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .MemoryRead  (MemoryRead),
        .MemoryWrite (MemoryWrite),
        .Address     (Address),
        .Size        (Size),
        .Unsigned    (Unsigned),
        .WriteData   (WriteData),
        .RespValid   (RespValid),
        .ReadData    (ReadData),
        .AccessError (AccessError)
`ifdef DMEM_PARITY_EN
        ,
        .ParityError (ParityError)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        par;
        int          acc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] model [DEPTH*4];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: memory as a flat byte array, access rules from plain arithmetic.
    function automatic exp_t model_req(input bit rd, input bit wr, input int a,
                                       input int size, input bit uns, input logic [31:0] wd);
        exp_t        r;
        int          n;
        logic [31:0] v;
        bit          err;
        n   = 1 << size;
        err = (size == 3) || (rd && wr) || ((a % n) != 0) || ((a / 4) >= DEPTH);
        r.data = 32'd0;
        r.err  = err;
        r.par  = 1'b0;
        r.acc  = 0;
        if (!err && wr) begin
            for (int i = 0; i < n; i++) model[a + i] = wd[8*i +: 8];
        end else if (!err && rd) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(model[a + i]) << (8 * i));
            if (!uns && n < 4 && v[8*n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            r.data = v;
        end
        return r;
    endfunction

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset && RespValid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got RespValid=1 data %h expected no response", ReadData);
            end else begin
                e = q.pop_front();
                check("resp_data", ReadData, e.data);
                check("resp_err", 32'(AccessError), 32'(e.err));
                check("latency", 32'(cyc - e.acc + 1), 32'(WS + 1));
`ifdef DMEM_PARITY_EN
                check("resp_parity", 32'(ParityError), 32'(e.par));
`endif
            end
        end
    end

    // Issue one request at a negedge; the following posedge accepts it.
    task automatic req(input bit rd, input bit wr, input int a, input int size,
                       input bit uns, input logic [31:0] wd,
                       input bit want_resp = 1'b1, input bit exp_par = 1'b0);
        exp_t e;
        int   k;
        k = 0;
        @(negedge Clock);
        while (!ReqReady && k < 50) begin
            @(negedge Clock);
            k++;
        end
        if (!ReqReady) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got ReqReady=0 expected 1 within 50 cycles");
            return;
        end
        ReqValid    = 1'b1;
        MemoryRead  = rd;
        MemoryWrite = wr;
        Address     = AW'(a);
        Size        = 2'(size);
        Unsigned    = uns;
        WriteData   = wd;
        if (rd || wr) begin
            e     = model_req(rd, wr, a, size, uns, wd);
            e.par = exp_par;
            e.acc = cyc + 1;
            if (want_resp) q.push_back(e);
        end
        @(negedge Clock);
        ReqValid    = 1'b0;
        MemoryRead  = 1'b0;
        MemoryWrite = 1'b0;
        if (!(rd || wr)) check("ignored_ready", 32'(ReqReady), 32'd1);
    endtask

    initial begin
        int k;
        Reset = 1'b1; ReqValid = 1'b0; MemoryRead = 1'b0; MemoryWrite = 1'b0;
        Address = '0; Size = 2'd0; Unsigned = 1'b0; WriteData = 32'd0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        check("reset_ready", 32'(ReqReady), 32'd1);
        check("reset_respvalid", 32'(RespValid), 32'd0);
        check("reset_readdata", ReadData, 32'd0);
        check("reset_accesserror", 32'(AccessError), 32'd0);

        // Give every word a known value.
        for (int w = 0; w < DEPTH; w++) req(1'b0, 1'b1, w * 4, 2, 1'b0, $urandom);

        // Word store/load, byte overlay, sign/zero extension.
        req(1'b0, 1'b1, 32'h10, 2, 1'b0, 32'hDEADBEEF);
        req(1'b1, 1'b0, 32'h10, 2, 1'b0, 32'h0);
        req(1'b0, 1'b1, 32'h11, 0, 1'b0, 32'h0000007F);
        req(1'b1, 1'b0, 32'h11, 0, 1'b0, 32'h0);
        req(1'b1, 1'b0, 32'h10, 2, 1'b0, 32'h0);
        req(1'b1, 1'b0, 32'h12, 1, 1'b0, 32'h0);
        req(1'b1, 1'b0, 32'h12, 1, 1'b1, 32'h0);
        req(1'b1, 1'b0, 32'h13, 0, 1'b0, 32'h0);

        // Error cases, then confirm the array is unchanged.
        req(1'b1, 1'b0, 32'h12, 2, 1'b0, 32'h0);
        req(1'b0, 1'b1, 32'h01, 1, 1'b0, 32'h1234);
        req(1'b1, 1'b1, 32'h10, 2, 1'b0, 32'h5555AAAA);
        req(1'b0, 1'b1, DEPTH * 4, 2, 1'b0, 32'hCAFEF00D);
        req(1'b1, 1'b0, 32'h10, 2, 1'b0, 32'h0);
        req(1'b1, 1'b0, 32'h00, 2, 1'b0, 32'h0);
        req(1'b1, 1'b0, 32'h10, 3, 1'b0, 32'h0);

        // Request with neither read nor write is ignored.
        req(1'b0, 1'b0, 32'h10, 2, 1'b0, 32'h0);

`ifdef DMEM_PARITY_EN
        @(negedge Clock);
        dut.par_r[4][0] = ~dut.par_r[4][0];
        req(1'b1, 1'b0, 32'h10, 0, 1'b0, 32'h0, 1'b1, 1'b1);
        req(1'b1, 1'b0, 32'h11, 0, 1'b0, 32'h0, 1'b1, 1'b0);
        req(1'b1, 1'b0, 32'h12, 1, 1'b1, 32'h0, 1'b1, 1'b0);
        req(1'b0, 1'b1, 32'h10, 2, 1'b0, 32'h0BADC0DE);
`endif

        // Reset during WAIT: no response, store stays committed.
        req(1'b0, 1'b1, 32'h20, 2, 1'b0, 32'h13579BDF, 1'b0);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check("midreset_ready", 32'(ReqReady), 32'd1);
        check("midreset_respvalid", 32'(RespValid), 32'd0);
        repeat (3) @(negedge Clock);
        req(1'b1, 1'b0, 32'h20, 2, 1'b0, 32'h0);
        req(1'b1, 1'b0, 32'h22, 1, 1'b1, 32'h0);

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            int op, sz, a;
            op = $urandom_range(0, 9);
            sz = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, DEPTH * 4 - 1);
            req(op < 4 || op == 8, (op >= 4 && op < 8) || op == 8, a, sz, $urandom_range(0, 1), $urandom);
        end

        // Drain outstanding responses.
        k = 0;
        while (q.size() != 0 && k < 20) begin
            @(negedge Clock);
            k++;
        end
        check("drain_outstanding", 32'(q.size()), 32'd0);
        repeat (2) @(negedge Clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
